// File: rtl/priority_mux_pipe.sv
// priority_mux_pipe: leading-one priority mux feeding a single-stage valid/ready output register.
// Optional feature macro: PRIO_MUX_COLL_CNT_EN adds a saturating 16-bit priority-collision counter.
module priority_mux_pipe #(
    parameter int NUM_IN = 6,
    parameter int WIDTH  = 8,
    localparam int CH_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] d_in,
    input  logic [NUM_IN-2:0]       sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        d_out,
    output logic [CH_W-1:0]         ch_idx,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef PRIO_MUX_COLL_CNT_EN
    ,
    output logic [15:0]             coll_cnt
`endif
);

    generate
        if (NUM_IN < 2 || NUM_IN > 32) begin : g_bad_num_in
            $error("priority_mux_pipe: NUM_IN must be in 2..32");
        end
    endgenerate

    logic [WIDTH-1:0] ch_data [NUM_IN];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_unpack
            assign ch_data[gi] = d_in[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Later iterations overwrite earlier ones, so the highest set bit wins.
    logic [CH_W-1:0] sel_ch;
    always_comb begin
        sel_ch = '0;
        for (int i = 0; i < NUM_IN - 1; i++) begin
            if (sel[i]) begin
                sel_ch = CH_W'(i + 1);
            end
        end
    end

    logic [WIDTH-1:0] d_out_q, d_out_d;
    logic [CH_W-1:0]  ch_idx_q, ch_idx_d;
    logic             out_valid_q, out_valid_d;
    logic             accept;
    logic             pop;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid_q && out_ready;

    always_comb begin
        d_out_d     = d_out_q;
        ch_idx_d    = ch_idx_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            d_out_d     = ch_data[sel_ch];
            ch_idx_d    = sel_ch;
            out_valid_d = 1'b1;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_out_q     <= '0;
            ch_idx_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            d_out_q     <= d_out_d;
            ch_idx_q    <= ch_idx_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign d_out     = d_out_q;
    assign ch_idx    = ch_idx_q;
    assign out_valid = out_valid_q;

`ifdef PRIO_MUX_COLL_CNT_EN
    localparam logic [NUM_IN-2:0] SEL_ONE = (NUM_IN-1)'(1);

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    logic        sel_multi;
    logic [15:0] coll_cnt_q, coll_cnt_d;

    assign sel_multi = (sel & (sel - SEL_ONE)) != '0;

    always_comb begin
        coll_cnt_d = coll_cnt_q;
        if (accept && sel_multi && coll_cnt_q != 16'hFFFF) begin
            coll_cnt_d = coll_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coll_cnt_q <= '0;
        end else begin
            coll_cnt_q <= coll_cnt_d;
        end
    end

    assign coll_cnt = coll_cnt_q;
`endif

endmodule

// File: tb/tb_priority_mux_pipe.sv
// Self-checking bench for priority_mux_pipe: directed sweeps plus randomized traffic against a scoreboard model.
module tb_priority_mux_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // NUM_IN=6, WIDTH=8 instance
    logic [47:0] d_in6 = '0;
    logic [4:0]  sel6 = '0;
    logic        iv6 = 1'b0, or6 = 1'b0;
    logic        ir6, ov6;
    logic [7:0]  dout6;
    logic [2:0]  ch6;
`ifdef PRIO_MUX_COLL_CNT_EN
    logic [15:0] coll6, coll2, coll32;
`endif

    // NUM_IN=2, WIDTH=16 instance
    logic [31:0] d_in2 = '0;
    logic [0:0]  sel2 = '0;
    logic        ir2, ov2;
    logic [15:0] dout2;
    logic [0:0]  ch2;

    // NUM_IN=32, WIDTH=8 instance
    logic [255:0] d_in32 = '0;
    logic [30:0]  sel32 = '0;
    logic         ir32, ov32;
    logic [7:0]   dout32;
    logic [4:0]   ch32;

    logic one = 1'b1;

    priority_mux_pipe #(.NUM_IN(6), .WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .d_in(d_in6), .sel(sel6), .in_valid(iv6), .in_ready(ir6),
        .d_out(dout6), .ch_idx(ch6), .out_valid(ov6), .out_ready(or6)
`ifdef PRIO_MUX_COLL_CNT_EN
        , .coll_cnt(coll6)
`endif
    );

    priority_mux_pipe #(.NUM_IN(2), .WIDTH(16)) u_dut2 (
        .clk(clk), .rst(rst), .d_in(d_in2), .sel(sel2), .in_valid(one), .in_ready(ir2),
        .d_out(dout2), .ch_idx(ch2), .out_valid(ov2), .out_ready(one)
`ifdef PRIO_MUX_COLL_CNT_EN
        , .coll_cnt(coll2)
`endif
    );

    priority_mux_pipe #(.NUM_IN(32), .WIDTH(8)) u_dut32 (
        .clk(clk), .rst(rst), .d_in(d_in32), .sel(sel32), .in_valid(one), .in_ready(ir32),
        .d_out(dout32), .ch_idx(ch32), .out_valid(ov32), .out_ready(one)
`ifdef PRIO_MUX_COLL_CNT_EN
        , .coll_cnt(coll32)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: channel = 1 + position of highest set bit, or 0 for sel==0.
    function automatic int ref_ch(input logic [30:0] s);
        longint unsigned v;
        v = 64'(s);
        if (v == 0) return 0;
        return $clog2(v + 1);
    endfunction

    function automatic logic [7:0] byte_of(input logic [255:0] bus, input int k);
        logic [255:0] sh;
        sh = bus >> (k * 8);
        return sh[7:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] chan6 [6] = '{8'hB8, 8'hF0, 8'h55, 8'h33, 8'hE3, 8'hAA};

    // Scoreboard state for the random phase
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_ch;
    int         exp_coll;

    initial begin
        int c;
        logic exp_ir;
        logic [15:0] w16;

        step();
        step();
        rst = 1'b0;
        check("reset_out_valid", 64'(ov6), 64'd0);
        check("reset_d_out", 64'(dout6), 64'd0);
        check("reset_ch_idx", 64'(ch6), 64'd0);
        check("reset_in_ready", 64'(ir6), 64'd1);

        // Sweep every select code with the fixed channel pattern
        for (int k = 0; k < 6; k++) d_in6[k*8 +: 8] = chan6[k];
        iv6 = 1'b1;
        or6 = 1'b1;
        for (int s = 0; s < 32; s++) begin
            sel6 = 5'(s);
            step();
            c = ref_ch(31'(s));
            $display("sweep sel=%02h d_out=%02h ch_idx=%0d", s, dout6, ch6);
            check("sweep_d_out", 64'(dout6), 64'(chan6[c]));
            check("sweep_ch_idx", 64'(ch6), 64'(c));
            check("sweep_valid", 64'(ov6), 64'd1);
        end

        // Backpressure
        sel6 = 5'b00100;
        step();
        check("bp_first", 64'(dout6), 64'h33);
        or6 = 1'b0;
        sel6 = 5'b10000;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_in_ready", 64'(ir6), 64'd0);
            step();
            $display("backpressure cycle %0d d_out=%02h out_valid=%0b", i, dout6, ov6);
            check("bp_d_out", 64'(dout6), 64'h33);
            check("bp_valid", 64'(ov6), 64'd1);
            check("bp_ch_idx", 64'(ch6), 64'd3);
        end
        or6 = 1'b1;
        #1;
        check("bp_release_ready", 64'(ir6), 64'd1);
        step();
        check("bp_release_d_out", 64'(dout6), 64'hAA);
        check("bp_release_ch", 64'(ch6), 64'd5);

        // Streaming: one new value per cycle, no bubbles
        for (int i = 0; i < 32; i++) begin
            sel6 = 5'(i);
            step();
            c = ref_ch(31'(i));
            $display("stream sel=%02h d_out=%02h out_valid=%0b", i, dout6, ov6);
            check("stream_valid", 64'(ov6), 64'd1);
            check("stream_d_out", 64'(dout6), 64'(chan6[c]));
        end

        // Reset while an output is stalled
        sel6 = 5'b01000;
        step();
        or6 = 1'b0;
        iv6 = 1'b0;
        step();
        check("prerst_valid", 64'(ov6), 64'd1);
        rst = 1'b1;
        iv6 = 1'b1;
        step();
        rst = 1'b0;
        iv6 = 1'b0;
        #1;
        check("midrst_valid", 64'(ov6), 64'd0);
        check("midrst_d_out", 64'(dout6), 64'd0);
        check("midrst_ch_idx", 64'(ch6), 64'd0);
        check("midrst_in_ready", 64'(ir6), 64'd1);

        // Generality: 2-input and 32-input instances
        d_in2 = {16'hBEEF, 16'h1234};
        sel2 = 1'b1;
        for (int k = 0; k < 32; k++) d_in32[k*8 +: 8] = 8'($urandom);
        sel32 = 31'h4000_0000;
        step();
        $display("gen2 d_out=%04h ch_idx=%0d / gen32 d_out=%02h ch_idx=%0d", dout2, ch2, dout32, ch32);
        check("gen2_d_out", 64'(dout2), 64'hBEEF);
        check("gen2_ch_idx", 64'(ch2), 64'd1);
        check("gen32_d_out", 64'(dout32), 64'(byte_of(d_in32, 31)));
        check("gen32_ch_idx", 64'(ch32), 64'd31);
        sel2 = 1'b0;
        step();
        check("gen2_sel0_d_out", 64'(dout2), 64'h1234);
        check("gen2_sel0_ch_idx", 64'(ch2), 64'd0);
        for (int i = 0; i < 20; i++) begin
            sel32 = 31'($urandom) >> $urandom_range(0, 30);
            step();
            c = ref_ch(sel32);
            $display("gen32 sel=%08h d_out=%02h ch_idx=%0d", sel32, dout32, ch32);
            check("gen32_rand_ch", 64'(ch32), 64'(c));
            check("gen32_rand_d_out", 64'(dout32), 64'(byte_of(d_in32, c)));
        end

        // Randomized traffic against the scoreboard
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_ch    = 0;
        exp_coll  = 0;
        for (int i = 0; i < 500; i++) begin
            rst   = ($urandom_range(0, 63) == 0);
            iv6   = 1'($urandom);
            or6   = ($urandom_range(0, 3) != 0);
            sel6  = 5'($urandom) >> $urandom_range(0, 4);
            d_in6 = {16'($urandom), 32'($urandom)};
            #1;
            exp_ir = !exp_valid || or6;
            check("rand_in_ready", 64'(ir6), 64'(exp_ir));
            if (rst) begin
                exp_valid = 1'b0;
                exp_data  = '0;
                exp_ch    = 0;
                exp_coll  = 0;
            end else if (iv6 && exp_ir) begin
                exp_ch    = ref_ch(31'(sel6));
                exp_data  = byte_of(256'(d_in6), exp_ch);
                exp_valid = 1'b1;
                if ($countones(sel6) >= 2 && exp_coll < 65535) exp_coll++;
            end else if (exp_valid && or6) begin
                exp_valid = 1'b0;
            end
            step();
            $display("rand rst=%0b iv=%0b or=%0b sel=%02h -> ov=%0b d_out=%02h ch=%0d", rst, iv6, or6, sel6, ov6, dout6, ch6);
            check("rand_valid", 64'(ov6), 64'(exp_valid));
            check("rand_d_out", 64'(dout6), 64'(exp_data));
            check("rand_ch_idx", 64'(ch6), 64'(exp_ch));
`ifdef PRIO_MUX_COLL_CNT_EN
            check("rand_coll", 64'(coll6), 64'(exp_coll));
`endif
        end
        rst = 1'b0;

`ifdef PRIO_MUX_COLL_CNT_EN
        // Collision counter: two of three accepts collide, then saturation
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("coll_reset", 64'(coll6), 64'd0);
        iv6 = 1'b1;
        or6 = 1'b1;
        sel6 = 5'b00011;
        step();
        sel6 = 5'b00100;
        step();
        sel6 = 5'b11000;
        step();
        iv6 = 1'b0;
        step();
        $display("coll after 3 accepts = %0d", coll6);
        check("coll_two", 64'(coll6), 64'd2);
        iv6 = 1'b1;
        sel6 = 5'b00011;
        for (int i = 0; i < 65537; i++) step();
        $display("coll after saturation run = %04h", coll6);
        check("coll_sat", 64'(coll6), 64'hFFFF);
        step();
        check("coll_sat_hold", 64'(coll6), 64'hFFFF);
        iv6 = 1'b0;
        w16 = coll6;
        step();
        check("coll_pop_no_change", 64'(coll6), 64'hFFFF);
        check("coll_pop_stable", 64'(coll6), 64'(w16));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/priority_mux_pipe.md
Name: priority_mux_pipe

Overview:
- Parametrised, registered successor to the 6-to-1 priority mux.
- Selects one of NUM_IN data channels of WIDTH bits using a leading-one priority code on sel.
- Registers the result behind a valid/ready handshake, so the block can sit between pipeline stages of a datapath.
- Output holds stable under backpressure.

Parameters:
- NUM_IN, 6: number of data channels; legal range 2..32. Elaboration error outside that range.
- WIDTH, 8: bits per channel.
- CH_W (localparam), clog2(NUM_IN): width of ch_idx.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous reset, active-high.
- d_in, input, NUM_IN*WIDTH: packed channels; channel k = d_in[k*WIDTH +: WIDTH].
- sel, input, NUM_IN-1: priority select code.
- in_valid, input, 1: d_in/sel valid this cycle.
- in_ready, output, 1: block can accept this cycle.
- d_out, output, WIDTH: registered selected data.
- ch_idx, output, CH_W: registered index of the selected channel.
- out_valid, output, 1: d_out/ch_idx valid.
- out_ready, input, 1: downstream accepts d_out.
- coll_cnt, output, 16: present only with PRIO_MUX_COLL_CNT_EN.

Behaviour:
- Clock/reset: single clock clk; rst is synchronous, active-high, sampled on the rising edge of clk.
- Reset values: d_out=0, ch_idx=0, out_valid=0, coll_cnt=0. in_ready=1 in the cycle after reset.
- Select mapping (combinational, pre-register):
  - sel==0 -> channel 0.
  - otherwise -> channel (index of highest set bit of sel)+1.
  - Lower set bits are ignored.
  - Example, NUM_IN=6: sel=5'b00011 -> ch2; sel=5'b10000..5'b11111 -> ch5.
- in_ready = !out_valid || out_ready (combinational; single-stage pipe, no skid buffer).
- Accept = in_valid && in_ready. On accept at edge N, d_out/ch_idx load and out_valid=1 from edge N; latency is 1 cycle.
- Output pop = out_valid && out_ready.
  - Pop without accept: out_valid clears next edge.
  - Pop and accept in the same cycle: new data loads, out_valid stays 1, no bubble.
- Backpressure: while out_valid && !out_ready, d_out/ch_idx/out_valid hold. in_ready=0; d_in/sel changes are ignored.
- in_valid=0: no register update, except that out_valid clears on pop.
- Reset mid-transfer: a pending output is discarded. rst has priority over accept/pop in the same cycle.
- Inputs are not registered before selection; the data path is purely combinational into the output register.

Optional Feature:
- Macro: PRIO_MUX_COLL_CNT_EN.
- Defined:
  - Adds 16-bit output coll_cnt.
  - Increments on every accept where sel has two or more bits set (a priority collision).
  - Saturates at 16'hFFFF.
  - Cleared only by rst.
  - Pop has no effect on the count.
- Undefined: port coll_cnt and its logic are absent; all other behaviour is identical.

Test Plan:
- Sweep: NUM_IN=6, WIDTH=8, d0..d5 = 8'hB8, 8'hF0, 8'h55, 8'h33, 8'hE3, 8'hAA. Sweep sel 0..31 with in_valid=1, out_ready=1.
  - Required: d_out = B8 (sel 0), F0 (1), 55 (2-3), 33 (4-7), E3 (8-15), AA (16-31), one cycle after each accept.
  - Required: ch_idx equals the matching channel number; zero mismatches.
- Backpressure: accept sel=5'b00100 (d_out=33), then hold out_ready=0 for 4 cycles while driving sel=5'b10000.
  - Required: d_out=33, out_valid=1, in_ready=0 throughout.
  - Required: after out_ready=1, the next accept yields AA.
- Streaming: in_valid and out_ready high every cycle, sel incrementing.
  - Required: out_valid stays 1 continuously with one new value per cycle (no bubbles).
- Reset: assert rst for 1 cycle while out_valid=1 and out_ready=0.
  - Required: next cycle out_valid=0, d_out=0, ch_idx=0, in_ready=1.
- Generality: NUM_IN=2, WIDTH=16, sel=1'b1.
  - Required: d_out = channel 1, ch_idx=1.
  - Repeat with NUM_IN=32, sel=31'h4000_0000 -> ch31.
- Collision counter (PRIO_MUX_COLL_CNT_EN defined): accept sel=5'b00011, 5'b00100, 5'b11000.
  - Required: coll_cnt=2.
  - Preload near saturation by 65537 collision accepts -> coll_cnt holds at 16'hFFFF.
